// File: rtl/msg_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msg_link_arbiter
//  Purpose  : Round-robin arbiter sharing one message/reply link among NREQ
//             requesters, with reply timeout, bounded retries and error report.
//  Revision : 1.0 - initial release
// ============================================================================
module msg_link_arbiter #(
    parameter int NREQ      = 4,
    parameter int REPLY_W   = 4,
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               link_msg,
    input  logic [REPLY_W-1:0] link_reply,
    output logic [REPLY_W-1:0] reply_data,
    output logic [NREQ-1:0]    done,
    output logic               err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RGAP = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    localparam logic [NREQ-1:0] c_ONEHOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [TW-1:0]      r_timer;
    logic [RW-1:0]      r_retry;
    logic [NREQ-1:0]    r_grant;
    logic               r_busy;
    logic               r_msg;
    logic [REPLY_W-1:0] r_reply;
    logic [NREQ-1:0]    r_done;
    logic               r_err;

    logic               w_found;
    logic [PW-1:0]      w_winner;
    logic [PW-1:0]      w_idx;

    // Round-robin search: first set request strictly after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Transaction sequencer: grant, message/reply handshake, timeout and retry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_timer <= '0;
            r_retry <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_msg   <= 1'b0;
            r_reply <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant <= c_ONEHOT0 << w_winner;
                        r_ptr   <= w_winner;
                        r_msg   <= 1'b1;
                        r_timer <= '0;
                        r_retry <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // A reply seen on the timeout cycle still counts as success.
                    if (link_reply != '0) begin
                        r_reply <= link_reply;
                        r_done  <= r_grant;
                        r_msg   <= 1'b0;
                        r_state <= c_GAP;
                    end else if (r_timer != TW'(TIMEOUT - 1)) begin
                        r_timer <= r_timer + TW'(1);
                    end else begin
                        r_msg <= 1'b0;
                        if (r_retry < RW'(MAX_RETRY)) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= c_RGAP;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_GAP;
                        end
                    end
                end
                c_RGAP: begin
                    r_msg   <= 1'b1;
                    r_timer <= '0;
                    r_state <= c_WAIT;
                end
                default: begin
                    // GAP: pulses end and the link is released.
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign link_msg   = r_msg;
    assign reply_data = r_reply;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_msg_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msg_link_arbiter
//  Purpose  : Directed self-checking bench for msg_link_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msg_link_arbiter;

    localparam int NREQ = 4;
    localparam int RW   = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] grant;
    logic          busy;
    logic          link_msg;
    logic [RW-1:0] link_reply;
    logic [RW-1:0] reply_data;
    logic [NREQ-1:0] done;
    logic          err;

    // Responder model: auto mode replies resp_val while link_msg is high,
    // manual mode drives manual_reply directly.
    logic          resp_auto    = 1'b1;
    logic [RW-1:0] resp_val     = 4'hF;
    logic [RW-1:0] manual_reply = '0;

    int checks = 0;
    int errors = 0;

    msg_link_arbiter #(.NREQ(4), .REPLY_W(4), .TIMEOUT(8), .MAX_RETRY(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .grant      (grant),
        .busy       (busy),
        .link_msg   (link_msg),
        .link_reply (link_reply),
        .reply_data (reply_data),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Responder behaviour selected by the stimulus.
    always_comb begin
        link_reply = '0;
        if (resp_auto) link_reply = link_msg ? resp_val : '0;
        else           link_reply = manual_reply;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"},      32'(grant),      32'h0);
        check({tag, ".busy"},       32'(busy),       32'h0);
        check({tag, ".link_msg"},   32'(link_msg),   32'h0);
        check({tag, ".reply_data"}, 32'(reply_data), 32'h0);
        check({tag, ".done"},       32'(done),       32'h0);
        check({tag, ".err"},        32'(err),        32'h0);
    endtask

    logic [NREQ-1:0] rr_exp [5];
    bit              exp_msg;

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        // Power-on reset
        #1;
        check_all_zero("por");
        #12;
        resetn = 1'b1;
        tick();

        // First request after reset
        req = 4'b0100;
        tick();
        check("t1a.grant", 32'(grant), 32'h4);
        check("t1a.busy",  32'(busy),  32'h1);
        req = '0;
        tick();
        check("t1a.done", 32'(done), 32'h4);
        tick();
        check("t1a.idle_grant", 32'(grant), 32'h0);

        // Reset in the middle of WAIT (pointer currently 2)
        resp_val = 4'h0;
        req = 4'b0001;
        tick();
        check("t1b.grant", 32'(grant), 32'h1);
        tick(); tick(); tick();
        check("t1b.msg_mid", 32'(link_msg), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("t1b.async");
        resetn = 1'b1;
        resp_val = 4'hF;
        req = 4'b0101;
        tick();
        check("t1b.ptr_reset_grant", 32'(grant), 32'h1);
        req = '0;
        tick();
        check("t1b.done", 32'(done), 32'h1);
        check("t1b.err",  32'(err),  32'h0);
        tick();
        check("t1b.release", 32'(grant), 32'h0);

        // Immediate reply latency (pointer at 0)
        req = 4'b0001;
        tick();
        check("t2.grant_E0", 32'(grant),    32'h1);
        check("t2.msg_E0",   32'(link_msg), 32'h1);
        req = '0;
        tick();
        check("t2.done_E1",  32'(done),       32'h1);
        check("t2.data_E1",  32'(reply_data), 32'hF);
        check("t2.msg_E1",   32'(link_msg),   32'h0);
        tick();
        check("t2.grant_E2", 32'(grant), 32'h0);
        check("t2.done_E2",  32'(done),  32'h0);
        check("t2.busy_E2",  32'(busy),  32'h0);

        // Round robin from a fresh pointer
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("t3.grant%0d", t), 32'(grant),    32'(rr_exp[t]));
            check($sformatf("t3.msg%0d", t),   32'(link_msg), 32'h1);
            if (t == 4) req = '0;
            tick();
            check($sformatf("t3.done%0d", t),  32'(done),     32'(rr_exp[t]));
            tick();
            check($sformatf("t3.gap%0d", t),   32'(link_msg), 32'h0);
            check($sformatf("t3.idle%0d", t),  32'(grant),    32'h0);
        end

        // Silent responder: three full attempts then err (pointer at 0)
        resp_val = 4'h0;
        req = 4'b0010;
        for (int c = 0; c < 28; c++) begin
            tick();
            if (c == 0) req = '0;
            exp_msg = !(c == 8 || c == 17 || c >= 26);
            check($sformatf("t4.msg%0d", c),  32'(link_msg), 32'(exp_msg));
            check($sformatf("t4.done%0d", c), 32'(done),     32'h0);
            check($sformatf("t4.err%0d", c),  32'(err),      32'(c == 26));
            if (c == 26) check("t4.victim", 32'(grant), 32'h2);
        end
        check("t4.data_kept", 32'(reply_data), 32'hF);
        check("t4.idle",      32'(grant),      32'h0);

        // Reply on the third WAIT cycle of attempt 2 (pointer at 1)
        resp_auto = 1'b0;
        manual_reply = '0;
        req = 4'b0010;
        tick();
        check("t5.grant", 32'(grant), 32'h2);
        req = '0;
        for (int c = 1; c <= 11; c++) tick();
        check("t5.msg_a2", 32'(link_msg), 32'h1);
        manual_reply = 4'h5;
        tick();
        manual_reply = '0;
        check("t5.done", 32'(done),       32'h2);
        check("t5.data", 32'(reply_data), 32'h5);
        check("t5.err",  32'(err),        32'h0);
        tick();
        check("t5.err2",  32'(err),   32'h0);
        check("t5.idle",  32'(grant), 32'h0);

        // Reply on the timeout cycle wins (pointer at 1)
        req = 4'b0010;
        tick();
        req = '0;
        for (int c = 1; c <= 7; c++) tick();
        check("t6a.msg_t7", 32'(link_msg), 32'h1);
        manual_reply = 4'hA;
        tick();
        manual_reply = '0;
        check("t6a.done", 32'(done),       32'h2);
        check("t6a.data", 32'(reply_data), 32'hA);
        tick();
        check("t6a.no_rgap", 32'(link_msg), 32'h0);
        check("t6a.err",     32'(err),      32'h0);
        check("t6a.idle",    32'(grant),    32'h0);

        // Request dropped mid-WAIT still completes (pointer at 1)
        req = 4'b0001;
        tick();
        check("t6b.grant", 32'(grant), 32'h1);
        tick(); tick();
        req = '0;
        tick();
        check("t6b.still", 32'(grant), 32'h1);
        manual_reply = 4'h3;
        tick();
        manual_reply = '0;
        check("t6b.done", 32'(done),       32'h1);
        check("t6b.data", 32'(reply_data), 32'h3);
        tick();
        check("t6b.idle", 32'(grant), 32'h0);
        check("t6b.busy", 32'(busy),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
